// File: rtl/fifo_datapath.sv
// fifo_datapath: storage and pointer datapath for the FIFO controller.
// Decodes the 5-bit control word into memory write/read, pointer advance and
// clear actions, and reports full/empty status back to the controller.
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   control_signals  [4] mem_we [3] mem_re [2] clear [1] rd_inc [0] wr_inc
//   data_in          write data, sampled when mem_we is accepted
//   status_signals   [0] full, [1] empty (combinational from registered count)
//   data_out         registered read data
//   data_valid       one-cycle pulse when data_out was updated by a read
//   count            occupancy, 0..DEPTH
//   overflow         sticky: write or write-advance attempted while full
//   underflow        sticky: read or read-advance attempted while empty
module fifo_datapath #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    control_signals,
    input  logic [DATA_WIDTH-1:0]         data_in,
    output logic [1:0]                    status_signals,
    output logic [DATA_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
    localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;

    logic mem_we, mem_re, clear, rd_inc, wr_inc;
    logic full, empty;
    logic we_ok, re_ok, wr_adv, rd_adv;
    logic wr_bad, rd_bad;

    // Control word decode
    assign mem_we = control_signals[4];
    assign mem_re = control_signals[3];
    assign clear  = control_signals[2];
    assign rd_inc = control_signals[1];
    assign wr_inc = control_signals[0];

    // Status derives only from count; pointer equality is ambiguous at wrap
    assign full           = (count == CNT_WIDTH'(DEPTH));
    assign empty          = (count == '0);
    assign status_signals = {empty, full};

    // Accepted actions are judged against the pre-edge count; clear masks all
    assign we_ok  = ~clear & mem_we & ~full;
    assign re_ok  = ~clear & mem_re & ~empty;
    assign wr_adv = ~clear & wr_inc & ~full;
    assign rd_adv = ~clear & rd_inc & ~empty;
    assign wr_bad = ~clear & (mem_we | wr_inc) & full;
    assign rd_bad = ~clear & (mem_re | rd_inc) & empty;

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (we_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers, occupancy, read data and sticky flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            data_valid <= 1'b0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_adv) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (rd_adv) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            // Simultaneous accepted advances leave occupancy unchanged
            if (wr_adv && !rd_adv) begin
                count <= count + CNT_WIDTH'(1);
            end else if (rd_adv && !wr_adv) begin
                count <= count - CNT_WIDTH'(1);
            end
            if (re_ok) begin
                data_out <= mem[rd_ptr];
            end
            data_valid <= re_ok;
            if (wr_bad) begin
                overflow <= 1'b1;
            end
            if (rd_bad) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_datapath.sv
// Self-checking bench for fifo_datapath: table-driven fill/drain/overflow/
// underflow/clear vectors, then hand sequences for pointer wrap, clear of
// sticky flags and asynchronous reset between clock edges.
module tb_fifo_datapath;

    localparam int unsigned DW = 8;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned NVEC = 21;

    localparam logic [4:0] C_IDLE  = 5'b00000;
    localparam logic [4:0] C_WRITE = 5'b10001;
    localparam logic [4:0] C_READ  = 5'b01010;
    localparam logic [4:0] C_CLEAR = 5'b00100;

    typedef struct packed {
        logic [4:0]    ctrl;
        logic [DW-1:0] din;
        logic [3:0]    cnt;
        logic [1:0]    st;
        logic          dv;
        logic [DW-1:0] dout;
        logic          ovf;
        logic          unf;
    } vec_t;

    logic          clk;
    logic          rst;
    logic [4:0]    control_signals;
    logic [DW-1:0] data_in;
    logic [1:0]    status_signals;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic [3:0]    count;
    logic          overflow;
    logic          underflow;

    int total;
    int bad;
    vec_t vecs [NVEC];

    fifo_datapath #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .control_signals (control_signals),
        .data_in         (data_in),
        .status_signals  (status_signals),
        .data_out        (data_out),
        .data_valid      (data_valid),
        .count           (count),
        .overflow        (overflow),
        .underflow       (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Drive a control word away from the edge, then sample just after it
    task automatic step(input logic [4:0] ctrl, input logic [DW-1:0] din);
        @(negedge clk);
        control_signals = ctrl;
        data_in = din;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, ".count"}, int'(count), int'(v.cnt));
        check({tag, ".status"}, int'(status_signals), int'(v.st));
        check({tag, ".data_valid"}, int'(data_valid), int'(v.dv));
        check({tag, ".data_out"}, int'(data_out), int'(v.dout));
        check({tag, ".overflow"}, int'(overflow), int'(v.ovf));
        check({tag, ".underflow"}, int'(underflow), int'(v.unf));
    endtask

    function automatic vec_t mk(input logic [4:0] c, input logic [DW-1:0] d,
                                input logic [3:0] n, input logic [1:0] s,
                                input logic v, input logic [DW-1:0] o,
                                input logic ov, input logic un);
        vec_t r;
        r.ctrl = c; r.din = d; r.cnt = n; r.st = s;
        r.dv = v; r.dout = o; r.ovf = ov; r.unf = un;
        return r;
    endfunction

    initial begin
        vec_t  e;
        logic [DW-1:0] exp_byte;
        total = 0;
        bad = 0;

        // Expected behaviour from reset: fill, overflow, drain, underflow, clear
        vecs[0] = mk(C_IDLE, 8'h00, 4'd0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vecs[1+i] = mk(C_WRITE, 8'hA0 + 8'(i), 4'(i + 1),
                           (i == 7) ? 2'b01 : 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        vecs[9] = mk(C_WRITE, 8'hFF, 4'd8, 2'b01, 1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            vecs[10+i] = mk(C_READ, 8'h00, 4'(7 - i),
                            (i == 7) ? 2'b10 : 2'b00, 1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0);
        end
        vecs[18] = mk(C_READ, 8'h00, 4'd0, 2'b10, 1'b0, 8'hA7, 1'b1, 1'b1);
        vecs[19] = mk(C_IDLE, 8'h00, 4'd0, 2'b10, 1'b0, 8'hA7, 1'b1, 1'b1);
        vecs[20] = mk(C_CLEAR, 8'h00, 4'd0, 2'b10, 1'b0, 8'hA7, 1'b0, 1'b0);

        control_signals = C_IDLE;
        data_in = '0;
        rst = 1'b1;
        #12;
        check("reset.count", int'(count), 0);
        check("reset.status", int'(status_signals), 2);
        check("reset.data_valid", int'(data_valid), 0);
        check("reset.overflow", int'(overflow), 0);
        check("reset.underflow", int'(underflow), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].ctrl, vecs[i].din);
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // Pointer wrap: pointers sit at 0 after clear; write 5, read 5, write 8, read 8
        for (int i = 0; i < 5; i++) step(C_WRITE, 8'hC0 + 8'(i));
        check("wrap.count5", int'(count), 5);
        for (int i = 0; i < 5; i++) begin
            step(C_READ, 8'h00);
            check($sformatf("wrap.c%0d", i), int'(data_out), int'(8'hC0 + 8'(i)));
        end
        for (int i = 0; i < 8; i++) step(C_WRITE, 8'hB0 + 8'(i));
        check("wrap.count8", int'(count), 8);
        check("wrap.full", int'(status_signals), 1);
        for (int i = 0; i < 8; i++) begin
            step(C_READ, 8'h00);
            exp_byte = 8'hB0 + 8'(i);
            check($sformatf("wrap.b%0d", i), int'(data_out), int'(exp_byte));
            check($sformatf("wrap.dv%0d", i), int'(data_valid), 1);
        end
        check("wrap.count0", int'(count), 0);
        step(C_IDLE, 8'h00);
        check("wrap.dv_drop", int'(data_valid), 0);

        // Clear wipes occupancy and sticky flags
        step(C_READ, 8'h00);
        check("clr.pre_unf", int'(underflow), 1);
        for (int i = 0; i < 3; i++) step(C_WRITE, 8'hD0 + 8'(i));
        check("clr.pre_count", int'(count), 3);
        step(C_CLEAR, 8'h00);
        e = mk(C_CLEAR, 8'h00, 4'd0, 2'b10, 1'b0, 8'hB7, 1'b0, 1'b0);
        check_all("clr", e);

        // Asynchronous reset between edges with nonzero state
        for (int i = 0; i < 3; i++) step(C_WRITE, 8'hE0 + 8'(i));
        step(C_READ, 8'h00);
        check("arst.pre_dout", int'(data_out), int'(8'hE0));
        check("arst.pre_dv", int'(data_valid), 1);
        @(negedge clk);
        control_signals = C_WRITE;
        data_in = 8'h55;
        #2;
        rst = 1'b1;
        #1;
        e = mk(C_WRITE, 8'h55, 4'd0, 2'b10, 1'b0, 8'h00, 1'b0, 1'b0);
        check_all("arst", e);
        @(negedge clk);
        rst = 1'b0;
        control_signals = C_IDLE;
        // Pointers were reset too: next write/read pair returns the new word
        step(C_WRITE, 8'h5A);
        step(C_READ, 8'h00);
        check("arst.post_dout", int'(data_out), int'(8'h5A));
        check("arst.post_count", int'(count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
